// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data-memory access path.
// Access-size codes, FSM states and size/alignment helpers.
package mem_pkg;

    localparam logic [1:0] BHW_WORD = 2'b00;
    localparam logic [1:0] BHW_HALF = 2'b01;
    localparam logic [1:0] BHW_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } mem_state_t;

    // The reserved code 2'b11 behaves exactly like a word access.
    function automatic logic [1:0] norm_bhw(input logic [1:0] bhw);
        return (bhw == 2'b11) ? BHW_WORD : bhw;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] bhw, input logic [1:0] off);
        logic r;
        case (bhw)
            BHW_HALF: r = off[0];
            BHW_BYTE: r = 1'b0;
            default:  r = (off != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/ack port: the master drives the request, the memory answers with ack/rdata.
// Ack and rdata are only meaningful while the request is held high.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables / replicated data, and load extract/extend.
// Zero latency; no flow control. Store and load halves are independent so each side can be reused alone.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_st_bhw,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [1:0]  i_ld_bhw,
    input  logic [1:0]  i_ld_off,
    input  logic        i_ld_sign,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_st_data;
        case (i_st_bhw)
            BHW_BYTE: begin
                o_be    = 4'b0001 << i_st_off;
                o_wdata = {4{i_st_data[7:0]}};
            end
            BHW_HALF: begin
                o_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_st_data;
            end
        endcase
    end

    always_comb begin
        w_ld_byte = i_ld_rdata[7:0];
        case (i_ld_off)
            2'd0:    w_ld_byte = i_ld_rdata[7:0];
            2'd1:    w_ld_byte = i_ld_rdata[15:8];
            2'd2:    w_ld_byte = i_ld_rdata[23:16];
            default: w_ld_byte = i_ld_rdata[31:24];
        endcase
        w_ld_half = i_ld_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    end

    always_comb begin
        o_ld_data = i_ld_rdata;
        case (i_ld_bhw)
            BHW_BYTE: o_ld_data = {{24{i_ld_sign & w_ld_byte[7]}}, w_ld_byte};
            BHW_HALF: o_ld_data = {{16{i_ld_sign & w_ld_half[15]}}, w_ld_half};
            default:  o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns EX/MEM controls into one req/ack transaction and stalls the pipe meanwhile.
// Latency: 1 detect cycle + 1..TIMEOUT_CYCLES wait cycles, result in the following DONE cycle; stall held until then.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [1:0]        BHW_in,
    input  logic              DataMemExtendSign_in,
    input  logic [ADDR_W-1:0] ALUResult_in,
    input  logic [31:0]       ReadData2_in,
    mem_access_unit_if.master dmem,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misalign_exc,
    output logic              bus_err
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t r_state;
    mem_state_t w_next_state;

    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_bhw;
    logic              r_sign;
    logic              r_we;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_access;
    logic [1:0]        w_bhw;
    logic              w_misaligned;
    logic              w_start;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_ld_ext;
    logic              w_timeout;
    logic              w_load_ok;

    assign w_access     = MemRead_in | MemWrite_in;
    assign w_bhw        = norm_bhw(BHW_in);
    assign w_misaligned = is_misaligned(w_bhw, ALUResult_in[1:0]);
    assign w_start      = (r_state == ST_IDLE) && w_access && !w_misaligned;
    assign w_timeout    = (r_cnt == CNT_LAST);
    assign w_load_ok    = !r_err && !r_we;

    mem_lane_align u_lane_align (
        .i_st_bhw   (w_bhw),
        .i_st_off   (ALUResult_in[1:0]),
        .i_st_data  (ReadData2_in),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .i_ld_bhw   (r_bhw),
        .i_ld_off   (r_addr[1:0]),
        .i_ld_sign  (r_sign),
        .i_ld_rdata (r_rdata),
        .o_ld_data  (w_ld_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        stall           = 1'b0;
        misalign_exc    = 1'b0;
        load_valid      = 1'b0;
        load_data       = 32'd0;
        bus_err         = 1'b0;
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_addr  = '0;
        dmem.dmem_be    = 4'b0000;
        dmem.dmem_wdata = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    if (w_misaligned) begin
                        misalign_exc = 1'b1;
                    end else begin
                        stall        = 1'b1;
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall           = 1'b1;
                dmem.dmem_req   = 1'b1;
                dmem.dmem_we    = r_we;
                dmem.dmem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
                dmem.dmem_be    = r_be;
                dmem.dmem_wdata = r_wdata;
                if (dmem.dmem_ack || w_timeout) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                // Inputs are deliberately ignored here so a still-held instruction is not re-issued.
                w_next_state = ST_IDLE;
                bus_err      = r_err;
                load_valid   = w_load_ok;
                load_data    = w_load_ok ? w_ld_ext : 32'd0;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_bhw   <= BHW_WORD;
            r_sign  <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= 4'b0000;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt   <= '0;
                r_addr  <= ALUResult_in;
                r_bhw   <= w_bhw;
                r_sign  <= DataMemExtendSign_in;
                r_we    <= MemWrite_in;
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_err   <= 1'b0;
            end else if (r_state == ST_WAIT) begin
                if (dmem.dmem_ack) begin
                    r_rdata <= dmem.dmem_rdata;
                    r_err   <= 1'b0;
                end else if (w_timeout) begin
                    r_err   <= 1'b1;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns MemRead/MemWrite, BHW, DataMemExtendSign, the ALU address and the store data into a req/ack transaction on the data-memory port.
- Generates byte enables and lane-replicated write data, and extracts and extends load data.
- Holds the pipeline with `stall` until the access completes, errors or times out.

Parameters:
- TIMEOUT_CYCLES, 16: maximum WAIT cycles without dmem_ack before a bus error is declared; must be ≥1.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- MemRead_in  in  1  load requested (from EX/MEM)
- MemWrite_in  in  1  store requested (from EX/MEM)
- BHW_in  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word
- DataMemExtendSign_in  in  1  1 = sign-extend sub-word loads, 0 = zero-extend
- ALUResult_in  in  ADDR_W  byte address
- ReadData2_in  in  32  store data (value in low bits)
- dmem_req  out  1  transaction request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- dmem_be  out  4  byte enables, little-endian lane 0 = bits 7:0
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  completion; valid only while dmem_req=1
- dmem_rdata  in  32  read word, valid with dmem_ack
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- load_data  out  32  extended load result
- load_valid  out  1  one-cycle pulse, load_data valid
- misalign_exc  out  1  one-cycle pulse, misaligned access rejected
- bus_err  out  1  one-cycle pulse, timeout

Behaviour:
- Reset: synchronous; state=IDLE, timeout counter=0, all latched address/data/size regs=0. Every output reads 0 in the cycle after rst is sampled high. rst during WAIT drops dmem_req the next cycle; a later ack is ignored.
- Access = MemWrite_in | MemRead_in. If both are high, it is a store (write wins).
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠00.
- FSM states IDLE, WAIT, DONE.
- IDLE, no access: all outputs 0.
- IDLE, misaligned access: misalign_exc=1 combinationally, stall=0, stay IDLE, no request issued.
- IDLE, aligned access: stall=1 combinationally. Latch addr, size, sign, we, be, wdata. Go to WAIT; counter cleared.
- WAIT: dmem_req=1, and dmem_we/addr/be/wdata come from the latched regs; stall=1.
  - Ack sampled high: capture dmem_rdata, go to DONE.
  - Else counter+1. When counter reaches TIMEOUT_CYCLES-1 without ack, go to DONE with err flag set.
- DONE: stall=0, dmem_req=0; always return to IDLE.
  - Load with no error: load_valid=1, load_data=extended value.
  - Error: bus_err=1, load_data=0, load_valid=0.
  - Inputs are not re-sampled in DONE, so the same instruction is never re-issued.
- Latency: at least 2 stall cycles (IDLE detect, WAIT with same-cycle ack), then DONE. At most TIMEOUT_CYCLES+1 stall cycles.
- Byte enables: byte → 1<<addr[1:0]; half → addr[1] ? 1100 : 0011; word → 1111.
- Write data: byte → {4{d[7:0]}}; half → {2{d[15:0]}}; word → d.
- Load extract: byte → rdata lane addr[1:0]; half → addr[1] ? [31:16] : [15:0]. Extend to 32 bits by sign bit or zeros per the latched sign flag. Word → rdata unchanged.
- ack outside WAIT: ignored.
- dmem_rdata: don't-care on stores.

Decomposition:
- Shared package mem_pkg:
  - BHW encodings: BHW_WORD=2'b00, BHW_HALF=2'b01, BHW_BYTE=2'b10.
  - FSM state encoding.
- Sub-module mem_lane_align (combinational) holds be/wdata generation and load extract/extend, so the WB stage can reuse it.
- FSM and counter stay in the top module.

Test Plan:
- Word store: addr 0x1000, data 0xDEADBEEF, ack on first WAIT cycle → dmem_be=1111, wdata=0xDEADBEEF, we=1, stall high exactly 2 cycles, no load_valid.
- Signed byte load: addr 0x2003, rdata 0x80FF_0000, ack after 3 WAIT cycles, sign=1 → load_data=0xFFFFFF80, load_valid one pulse, stall 4 cycles. Same with sign=0 → 0x00000080.
- Half store: addr 0x0006, data 0x1234ABCD → be=1100, wdata=0xABCDABCD, dmem_addr=0x0004.
- Misaligned: half load at 0x0005 and word store at 0x0002 → misalign_exc pulse, dmem_req never high, stall=0.
- Timeout: TIMEOUT_CYCLES=4, no ack → dmem_req high 4 cycles, bus_err pulse, load_data=0, back to IDLE. A late ack is ignored.
- Reset mid-WAIT: rst high for one cycle in WAIT → next cycle all outputs 0, state IDLE. An ack the following cycle produces no load_valid. Both MemRead and MemWrite high → store issued.
